serial_adder: RTL and testbench

Bit-serial N-bit adder built around a single full-adder cell (sum = a^b^c, carry = majority) and a carry flip-flop. It is the sequential stage downstream of the full-adder cell: it feeds that cell one operand bit pair per clock and consumes its sum and carry. It trades WIDTH cycles of latency for one adder cell, for area-limited datapaths in the design.

---
 rtl/serial_adder.sv | 121 ++++++++++++
 tb/tb_serial_adder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//   Bit-serial WIDTH-bit adder built around one full-adder cell and a carry
//   flip-flop. It processes one operand bit pair per clock, LSB first, so
//   a result takes WIDTH cycles and the adder itself costs one cell.
//
//   Optional feature macro: SERIAL_ADDER_OVF_EN
//     defined   -> ovf reports signed two's-complement overflow of the last
//                  result.
//     undefined -> ovf is tied to 0 and no overflow logic is built.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset; it wins over start
//   start  in   request a new addition; honoured in IDLE or DONE only
//   a, b   in   operands, captured on the accepting edge only
//   cin    in   carry-in, captured on the accepting edge only
//   busy   out  high while bits are being processed (state RUN)
//   done   out  one-cycle pulse; sum/cout/ovf are valid in this cycle
//   sum    out  result; holds the last completed value
//   cout   out  carry-out; holds the last completed value
//   ovf    out  signed overflow of the last result
// ---------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] ss;
    logic             c;
    logic [CW-1:0]    cnt;

    // The single full-adder cell, fed from the low end of the shifters.
    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] ss_next;

    assign fa_s    = sa[0] ^ sb[0] ^ c;
    assign fa_c    = (sa[0] & sb[0]) | (sa[0] & c) | (sb[0] & c);
    assign ss_next = {fa_s, ss[WIDTH-1:1]};

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q;
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            sa    <= '0;
            sb    <= '0;
            ss    <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        c     <= cin;
                        cnt   <= '0;
                        state <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    c   <= fa_c;
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    ss  <= ss_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        sum   <= ss_next;
                        cout  <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
                        // c still holds the carry into the MSB here.
                        ovf_q <= c ^ fa_c;
`endif
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//   Self-checking bench for serial_adder (WIDTH=8). Inputs are driven and
//   outputs sampled on the falling edge; expected results come from plain
//   integer arithmetic on the operands.
// ---------------------------------------------------------------------------
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_chk  = 0;
    int n_pass = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout),
        .ovf  (ovf)
    );

    always #5 clk = ~clk;

    // Reference: plain unsigned and signed integer addition.
    function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic ci);
        int u, s;
        logic o;
        u = int'(x) + int'(y) + int'(ci);
        s = int'($signed(x)) + int'($signed(y)) + int'(ci);
`ifdef SERIAL_ADDER_OVF_EN
        o = (s > 127) || (s < -128);
`else
        o = 1'b0;
`endif
        return {o, u[W], u[W-1:0]};
    endfunction

    // Called at a falling edge (cycle 0). Pulses start, scrambles the
    // operand inputs afterwards, and waits (bounded) for done.
    task automatic do_add(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic icin,
                          output logic [W-1:0] osum, output logic ocout, output logic oovf,
                          output int lat, output logic busy_ok, output logic held);
        logic [W-1:0] s0;
        s0      = sum;
        held    = 1'b1;
        busy_ok = 1'b1;
        start = 1'b1; a = ia; b = ib; cin = icin;
        @(negedge clk);
        start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        lat = 1;
        while (!done && lat < 30) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (sum !== s0) held = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (busy !== 1'b0) busy_ok = 1'b0;
        osum = sum; ocout = cout; oovf = ovf;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        n_chk++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
        n_chk++; if ({sum, cout, ovf} !== 10'd0)
            $display("FAIL reset_outputs got sum=%h cout=%b ovf=%b want 0", sum, cout, ovf);
        else n_pass++;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_idle_busy got %b want 0", busy); else n_pass++;
    endtask

    task automatic check_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic ci);
        logic [W-1:0] gs;
        logic gc, go, bok, hld;
        int lat;
        logic [W+1:0] e;
        e = ref_add(x, y, ci);
        do_add(x, y, ci, gs, gc, go, lat, bok, hld);
        n_chk++; if (lat !== 9) $display("FAIL %s_latency got %0d want 9", name, lat); else n_pass++;
        n_chk++; if (bok !== 1'b1) $display("FAIL %s_busy_window got %b want 1", name, bok); else n_pass++;
        n_chk++; if (hld !== 1'b1) $display("FAIL %s_sum_held got %b want 1", name, hld); else n_pass++;
        n_chk++; if ({go, gc, gs} !== e)
            $display("FAIL %s_result %h+%h+%b got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
                     name, x, y, ci, go, gc, gs, e[W+1], e[W], e[W-1:0]);
        else n_pass++;
        @(negedge clk);
        n_chk++; if (done !== 1'b0) $display("FAIL %s_done_pulse got %b want 0", name, done); else n_pass++;
        n_chk++; if (sum !== gs) $display("FAIL %s_sum_hold_after got %h want %h", name, sum, gs); else n_pass++;
    endtask

    task automatic test_directed;
        check_op("d0f01", 8'h0F, 8'h01, 1'b0);
        check_op("dff01", 8'hFF, 8'h01, 1'b0);
        check_op("dffff", 8'hFF, 8'hFF, 1'b1);
        check_op("d7f01", 8'h7F, 8'h01, 1'b0);
        check_op("d8080", 8'h80, 8'h80, 1'b0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 20; i++)
            check_op("rand", W'($urandom), W'($urandom), 1'($urandom));
    endtask

    task automatic test_start_ignored;
        int cyc;
        int extra;
        start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 30) begin
            if (cyc == 3) begin start = 1'b1; a = 8'hAA; b = 8'h55; end
            else start = 1'b0;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        n_chk++; if (cyc !== 9) $display("FAIL ign_latency got %0d want 9", cyc); else n_pass++;
        n_chk++; if (sum !== 8'h46) $display("FAIL ign_sum got %h want 46", sum); else n_pass++;
        extra = 0;
        repeat (12) begin @(negedge clk); if (done) extra++; end
        n_chk++; if (extra !== 0) $display("FAIL ign_second_done got %0d want 0", extra); else n_pass++;
    endtask

    task automatic test_reset_abort;
        int extra;
        start = 1'b1; a = 8'h05; b = 8'h03; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;                       // cycle 4
        @(negedge clk);
        n_chk++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else n_pass++;
        n_chk++; if (sum !== 8'h00) $display("FAIL abort_sum got %h want 00", sum); else n_pass++;
        n_chk++; if (done !== 1'b0) $display("FAIL abort_done got %b want 0", done); else n_pass++;
        rst = 1'b0;
        extra = 0;
        repeat (12) begin @(negedge clk); if (done || busy) extra++; end
        n_chk++; if (extra !== 0) $display("FAIL abort_activity got %0d want 0", extra); else n_pass++;
        check_op("after_abort", 8'h01, 8'h01, 1'b0);
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] gs;
        logic gc, go, bok, hld;
        int lat;
        do_add(8'h10, 8'h20, 1'b0, gs, gc, go, lat, bok, hld);
        n_chk++; if (gs !== 8'h30) $display("FAIL b2b_first_sum got %h want 30", gs); else n_pass++;
        // Still in the DONE cycle: start the next operation immediately.
        do_add(8'h01, 8'h02, 1'b0, gs, gc, go, lat, bok, hld);
        n_chk++; if (lat !== 9) $display("FAIL b2b_latency got %0d want 9", lat); else n_pass++;
        n_chk++; if (bok !== 1'b1) $display("FAIL b2b_busy_window got %b want 1", bok); else n_pass++;
        n_chk++; if (hld !== 1'b1) $display("FAIL b2b_sum_held got %b want 1", hld); else n_pass++;
        n_chk++; if (gs !== 8'h03) $display("FAIL b2b_second_sum got %h want 03", gs); else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        @(negedge clk);
        test_reset;
        test_directed;
        test_random;
        test_start_ignored;
        test_reset_abort;
        test_back_to_back;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
